// File: rtl/paraadd_acc_collect.sv
`default_nettype none
// ----------------------------------------------------------------------------
// paraadd_acc_collect : per-lane beat accumulator feeding a small output FIFO
// Revision 1.0
// ----------------------------------------------------------------------------
module paraadd_acc_collect #(
    parameter int LANES      = 8,
    parameter int LANE_W     = 16,
    parameter int BEATS      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LANES*LANE_W-1:0] addres_w,
    input  logic                    addres_v_w,
    input  logic                    flush,
    output logic [LANES*LANE_W-1:0] out_data,
    output logic                    out_v,
    input  logic                    out_ready,
    output logic                    stall,
    output logic                    ovf_err,
    output logic [3:0]              beat_cnt
);

    localparam int DATA_W = LANES * LANE_W;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

    logic [DATA_W-1:0] acc_q;
    logic [3:0]        k_q, k_d;
    logic [DATA_W-1:0] sum_w;
    logic [DATA_W-1:0] push_data_w;
    logic              push_w;
    logic              k_last_w;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              stall_q, ovf_q;
    logic              pop_w, full_w, wr_w, drop_w;

    // Lanes are added independently so no carry crosses a lane boundary.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign sum_w[l*LANE_W +: LANE_W] = (k_q == 4'd0)
            ? addres_w[l*LANE_W +: LANE_W]
            : acc_q[l*LANE_W +: LANE_W] + addres_w[l*LANE_W +: LANE_W];
    end

    assign k_last_w    = (k_q == 4'(BEATS - 1));
    assign push_w      = (addres_v_w && (k_last_w || flush))
                      || (!addres_v_w && flush && (k_q != 4'd0));
    assign push_data_w = addres_v_w ? sum_w : acc_q;

    always_comb begin
        k_d = k_q;
        if (push_w)
            k_d = 4'd0;
        else if (addres_v_w)
            k_d = k_q + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            k_q   <= 4'd0;
        end else begin
            if (addres_v_w)
                acc_q <= sum_w;
            k_q <= k_d;
        end
    end

    assign pop_w  = (count_q != '0) && out_ready;
    assign full_w = (count_q == CNT_W'(FIFO_DEPTH));
    assign wr_w   = push_w && (!full_w || pop_w);
    assign drop_w = push_w && full_w && !pop_w;

    always_comb begin
        count_d = count_q;
        if (wr_w && !pop_w)
            count_d = count_q + CNT_W'(1);
        else if (!wr_w && pop_w)
            count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            stall_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            if (wr_w)
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_w)
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
            stall_q <= (count_d >= CNT_W'(FIFO_DEPTH - 1));
            if (drop_w)
                ovf_q <= 1'b1;
        end
    end

    // Storage needs no reset: the head is masked whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (wr_w)
            mem_q[wr_ptr_q] <= push_data_w;
    end

    assign out_v    = (count_q != '0);
    assign out_data = out_v ? mem_q[rd_ptr_q] : '0;
    assign stall    = stall_q;
    assign ovf_err  = ovf_q;
    assign beat_cnt = k_q;

endmodule
`default_nettype wire

// File: tb/tb_paraadd_acc_collect.sv
`default_nettype none
// Bench for paraadd_acc_collect: directed test-plan steps plus random traffic
// checked every cycle against a queue-based reference model.
module tb_paraadd_acc_collect;

    localparam int LANES = 8;
    localparam int LW    = 16;
    localparam int DW    = LANES * LW;
    localparam int BEATS = 4;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] addres_w = '0;
    logic          addres_v_w = 1'b0;
    logic          flush = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_v;
    logic          out_ready = 1'b0;
    logic          stall;
    logic          ovf_err;
    logic [3:0]    beat_cnt;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] part  [$];
    bit            m_ovf   = 1'b0;
    bit            m_stall = 1'b0;

    paraadd_acc_collect #(
        .LANES(LANES), .LANE_W(LW), .BEATS(BEATS), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .addres_w(addres_w), .addres_v_w(addres_v_w),
        .flush(flush), .out_data(out_data), .out_v(out_v),
        .out_ready(out_ready), .stall(stall), .ovf_err(ovf_err),
        .beat_cnt(beat_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs,
                         input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] vsum();
        logic [DW-1:0] r = '0;
        for (int l = 0; l < LANES; l++) begin
            logic [LW-1:0] s = '0;
            foreach (part[j]) s = s + part[j][l*LW +: LW];
            r[l*LW +: LW] = s;
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] rnd();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One clock: drive inputs, advance the model, then compare all outputs.
    task automatic step(input bit r, input bit v, input bit f, input bit rdy,
                        input logic [DW-1:0] d);
        bit            pop, pushv;
        logic [DW-1:0] vec;
        @(negedge clk);
        rst = r; addres_v_w = v; flush = f; out_ready = rdy; addres_w = d;
        if (r) begin
            exp_q.delete(); part.delete(); m_ovf = 1'b0;
        end else begin
            pop   = (exp_q.size() != 0) && rdy;
            pushv = 1'b0;
            vec   = '0;
            if (v) part.push_back(d);
            if ((v && (part.size() == BEATS || f)) || (!v && f && part.size() > 0)) begin
                vec = vsum();
                part.delete();
                pushv = 1'b1;
            end
            if (pop) void'(exp_q.pop_front());
            if (pushv) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(vec);
                else m_ovf = 1'b1;
            end
        end
        m_stall = (exp_q.size() >= DEPTH - 1);
        @(posedge clk);
        #1;
        check("out_v",    DW'(out_v),    DW'(exp_q.size() != 0));
        check("out_data", out_data,      (exp_q.size() != 0) ? exp_q[0] : '0);
        check("stall",    DW'(stall),    DW'(m_stall));
        check("ovf_err",  DW'(ovf_err),  DW'(m_ovf));
        check("beat_cnt", DW'(beat_cnt), DW'(part.size()));
    endtask

    task automatic beat(input bit rdy, input logic [DW-1:0] d);
        step(1'b0, 1'b1, 1'b0, rdy, d);
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, 1'b0, 1'b0, rdy, '0);
    endtask

    initial begin
        logic [DW-1:0] e;
        logic [DW-1:0] d;

        // Reset state
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 1'b1, 1'b1, rnd());
        idle(1'b0);

        // Basic 4-beat accumulation with consumer ready
        for (int i = 1; i <= 4; i++) beat(1'b1, {{7{16'h0010}}, 16'(i)});
        e = {{7{16'h0040}}, 16'h000A};
        check("tp1_vector", out_data, e);
        idle(1'b1);

        // Lane wrap with no cross-lane carry
        for (int i = 0; i < 4; i++) begin
            d = rnd();
            d[63:48] = 16'hFFFF;
            beat(1'b0, d);
        end
        e = out_data;
        check("wrap_lane3", DW'(e[63:48]), DW'(16'hFFFC));
        idle(1'b1);

        // Flush after two beats, flush with a third beat, flush at k=0
        beat(1'b0, {8{16'd5}});
        beat(1'b0, {8{16'd7}});
        step(1'b0, 1'b0, 1'b1, 1'b0, '0);
        check("flush2_vector", out_data, {8{16'd12}});
        idle(1'b1);
        beat(1'b0, {8{16'd5}});
        beat(1'b0, {8{16'd7}});
        step(1'b0, 1'b1, 1'b1, 1'b0, {8{16'd9}});
        check("flush3_vector", out_data, {8{16'd21}});
        step(1'b0, 1'b0, 1'b1, 1'b0, '0);
        idle(1'b1);
        idle(1'b1);

        // Overflow: five vectors into a four-deep queue
        for (int i = 0; i < 5 * BEATS; i++) beat(1'b0, rnd());
        check("ovf_set", DW'(ovf_err), DW'(1));
        check("stall_full", DW'(stall), DW'(1));
        for (int i = 0; i < 5; i++) idle(1'b1);
        check("ovf_sticky", DW'(ovf_err), DW'(1));

        // Full queue with push and pop in the same cycle
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 4 * BEATS + 3; i++) beat(1'b0, rnd());
        beat(1'b1, rnd());
        check("pushpop_no_ovf", DW'(ovf_err), DW'(0));
        for (int i = 0; i < 5; i++) idle(1'b1);

        // Reset mid-operation
        for (int i = 0; i < 2 * BEATS + 2; i++) beat(1'b0, rnd());
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        check("rst_out_v", DW'(out_v), DW'(0));
        check("rst_beat_cnt", DW'(beat_cnt), DW'(0));
        for (int i = 0; i < BEATS; i++) beat(1'b0, {8{16'(i + 1)}});
        check("rst_post_vector", out_data, {8{16'd10}});
        idle(1'b1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 9) < 7,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 9) < 6,
                 rnd());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/paraadd_acc_collect.md
# paraadd_acc_collect

Downstream collector for the 8-lane parallel adder array. It captures every 128-bit adder result in the cycle it is valid, since the adder itself keeps no output register. It accumulates BEATS consecutive results per lane with modulo-2^16 arithmetic and queues each finished 128-bit vector in a small FIFO. The FIFO drains to the next stage over a valid/ready handshake, and a stall flag tells the operand issuer when to stop feeding the adder.

## Interface
Parameters:
- LANES, 8, number of independent 16-bit lanes packed in the data word
- LANE_W, 16, lane width in bits
- BEATS, 4, adder results accumulated per output vector (legal range 1..16)
- FIFO_DEPTH, 4, output queue entries (power of two, ≥2)

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- addres_w  in  LANES*LANE_W  adder result vector; lane i occupies bits [16i+15:16i]
- addres_v_w  in  1  addres_w valid this cycle; no backpressure is possible on this input
- flush  in  1  single-cycle pulse; closes the current partial accumulation
- out_data  out  LANES*LANE_W  FIFO head vector
- out_v  out  1  out_data valid (FIFO not empty)
- out_ready  in  1  consumer accepts out_data this cycle
- stall  out  1  upstream must stop issuing new adder operands
- ovf_err  out  1  sticky flag: a finished vector was dropped because the FIFO was full
- beat_cnt  out  4  number of beats already folded into the accumulator (debug)

## Operation
- Accumulator: one LANE_W register per lane.
  - Beat counter k runs 0..BEATS-1.
  - On a valid beat with k==0: acc ← addres_w.
  - On a valid beat with k>0: acc ← acc + addres_w, per lane, modulo 2^16, with no carry between lanes.
- Completion:
  - On a valid beat with k==BEATS-1, the vector sum = (k==0 ? addres_w : acc + addres_w) is pushed to the FIFO in the same cycle, and k ← 0.
  - With BEATS=1, every valid beat is pushed unchanged.
- Flush:
  - flush with no valid beat and k>0: push acc, k ← 0.
  - flush with no valid beat and k==0: no push, no effect.
  - flush coinciding with a valid beat: the beat is folded in first, then the sum is pushed regardless of k, and k ← 0.
- FIFO:
  - Circular buffer with read/write pointers and a count of 0..FIFO_DEPTH.
  - out_v = (count != 0); out_data = entry[rd_ptr].
  - Pop occurs when out_v && out_ready.
- Full FIFO:
  - A push with no pop in the same cycle is dropped. ovf_err ← 1 and holds until rst. Pointers and count are unchanged.
  - A push with a pop in the same cycle is accepted; count is unchanged.
- Empty FIFO: out_ready is ignored, and pointers do not move.
- Pointers wrap modulo FIFO_DEPTH.
- stall = (count ≥ FIFO_DEPTH-1), registered from the post-update count.
  - This leaves room for results already in flight (2-cycle adder latency) when BEATS ≥ 2.
  - With BEATS=1, loss on overrun is flagged through ovf_err.

## Timing
- Reset values:
  - out_v=0, out_data=0, stall=0, ovf_err=0, beat_cnt=0.
  - acc, FIFO pointers and count all 0; FIFO storage contents are don't-care but must not be visible.
- Reset mid-operation discards the partial accumulation and all queued vectors. The first beat after rst deasserts starts at k=0.
- Latency: final valid beat at cycle t → out_v=1 with that vector at cycle t+1, when the FIFO was empty.
- Pop at cycle t → the next entry, or out_v=0, appears at t+1.
- Throughput: one beat accepted every cycle, including back-to-back beats across vector boundaries with no bubble.
- stall updates one cycle after the count change that causes it.
- End-to-end: operands issued to the adder at cycle t appear on addres_w at t+2. Upstream therefore still delivers up to 2 beats after it samples stall=1.

## Test plan
- BEATS=4, lane 0 inputs 1,2,3,4 over 4 consecutive cycles, all other lanes 0x0010 each beat, out_ready=1 → one vector with lane0=0x000A and other lanes=0x0040, out_v high exactly one cycle after the 4th beat.
- Wrap: lane 3 inputs 0xFFFF ×4 → lane3=0xFFFC; lanes 2 and 4 unaffected (no cross-lane carry).
- Flush after 2 beats (5, 7) → vector 12 pushed, beat_cnt=0. Flush coincident with a 3rd beat (5, 7, 9) → 21 pushed. Flush at k=0 with no beat → no push.
- out_ready=0, FIFO_DEPTH=4, 5 completed vectors → stall=1 after count reaches 3, 4 entries held, 5th dropped, ovf_err=1. Draining then returns the 4 vectors in order and ovf_err stays 1.
- Full FIFO with push and pop in the same cycle → count stays 4, the pushed vector appears last in the drain order, ovf_err stays 0.
- rst asserted after 2 beats with 2 entries queued → next cycle out_v=0 and beat_cnt=0. The next 4 beats produce a vector containing only post-reset data.
